iob_dma_read: RTL and testbench
===============================

// Module: iob_dma_read
// PURPOSE
//  Read half of the DMA engine: the counterpart of the write path. Fetches r_length_i words from
//  memory over an AXI4 read master as INCR bursts and streams them out on an AXIS master port.
//  Bursts are split by r_max_len_i and by 4 KiB boundaries, and are buffered in a FIFO.
//  The FIFO's storage is the external RAM. A burst is issued only when its words fit in the FIFO.
// PARAMETERS
//  AXI_ADDR_W  32  byte address width
//  AXI_LEN_W   8   AXI len width; FIFO depth = 2**AXI_LEN_W words
//  AXI_DATA_W  32  data width (power of 2, >=8)
//  AXI_ID_W    1   AXI ID width
//  DMA_RLEN_W  24  transfer length width, in words (> AXI_LEN_W+1)
// PORTS
//  clk_i               in   1                clock
//  cke_i               in   1                clock enable; all state holds when low
//  rst_i               in   1                synchronous reset, active-high
//  r_addr_i            in   AXI_ADDR_W       start byte address (word aligned)
//  r_length_i          in   DMA_RLEN_W       words to transfer
//  r_start_transfer_i  in   1                start pulse
//  r_max_len_i         in   AXI_LEN_W+1      max burst length in words
//  r_remaining_data_o  out  DMA_RLEN_W       words not yet delivered on AXIS
//  r_busy_o            out  1                transfer in progress
//  r_error_o           out  1                sticky: an RRESP!=OKAY was seen in this transfer
//  axis_out_data_o     out  AXI_DATA_W       stream data
//  axis_out_valid_o    out  1                stream valid
//  axis_out_ready_i    in   1                stream ready
//  axis_out_last_o     out  1                high with the final word of the transfer
//  m_axi_ar{id,addr,len,size,burst,valid}_o / arready_i   AXI4 AR channel
//  m_axi_r{id,data,resp,last,valid}_i / rready_o          AXI4 R channel
//  ext_mem_{clk,w_en,w_addr,w_data,r_en,r_addr}_o, ext_mem_r_data_i
//                                            FIFO RAM: 2**AXI_LEN_W x AXI_DATA_W, 1-cycle read
// BEHAVIOUR
//  Reset:
//   - All outputs are 0 except m_axi_arsize_o and m_axi_arburst_o.
//   - Internal state: FSM=IDLE, FIFO empty, counters 0, r_error_o=0.
//   - Reset mid-transfer abandons the transfer immediately. Outstanding AXI beats are not drained.
//  FSM states: IDLE -> CALC -> ADDR -> DATA -> (CALC | DRAIN) -> IDLE.
//   - IDLE: r_busy_o=0.
//     - On r_start_transfer_i: latch addr and length; set r_remaining_data_o=r_length_i;
//       clear r_error_o.
//     - Go to CALC, or go to IDLE when r_length_i==0. Nothing is issued and no tlast occurs.
//     - r_start_transfer_i is ignored in every state except IDLE.
//   - CALC: compute blen = min(req_left, max_len, words_to_4K).
//     - max_len = r_max_len_i; a value of 0 is treated as 1; the value is capped at 2**AXI_LEN_W.
//     - words_to_4K = (4096 - addr[11:0]) / (AXI_DATA_W/8).
//     - Stay in CALC until FIFO free space >= blen, then go to ADDR.
//   - ADDR: arvalid=1, araddr=addr, arlen=blen-1, arsize=log2(AXI_DATA_W/8), arburst=2'b01,
//     arid=0.
//     - Hold all AR fields stable until arready. On the handshake go to DATA.
//   - DATA: rready=1 (space was reserved in CALC).
//     - Each rvalid beat is pushed into the FIFO.
//     - An rresp != 0 sets r_error_o; the beat is still forwarded.
//     - On the beat with rlast: addr += blen*(AXI_DATA_W/8) and req_left -= blen.
//       Then go to CALC if req_left>0, otherwise go to DRAIN.
//     - rlast arriving early or late is not checked; the beat count is trusted.
//   - DRAIN: wait until r_remaining_data_o==0, then go to IDLE.
//  One AR burst is outstanding at a time. rready is 0 outside DATA.
//  AXIS output:
//   - An output register is prefetched from the FIFO, so the FIFO-to-valid latency is 2 cycles.
//   - Sustains 1 word/cycle while the FIFO is non-empty and ready is high.
//   - Data and last stay stable while valid && !ready.
//   - Each handshake decrements r_remaining_data_o.
//   - axis_out_last_o = valid && (r_remaining_data_o==1).
//  r_busy_o is 1 from the cycle after start until the cycle after the final AXIS handshake.
//  Simultaneous FIFO push and pop in the same cycle is allowed; the level is unchanged.
//  Address arithmetic wraps modulo 2**AXI_ADDR_W.
// TESTING
//  T1: addr=0x1000, len=4, max=16, ready=1 -> one AR (len=3), 4 AXIS words, last on the 4th,
//      busy low afterwards.
//  T2: len=40, max=16 -> ARs with arlen 15,15,7 at addresses 0x0,0x40,0x80. Data is in order.
//  T3: addr=0xFF8, len=8, 32-bit data -> ARs at 0xFF8 (arlen=1) and 0x1000 (arlen=5).
//      No burst crosses a 4 KiB boundary.
//  T4: axis_out_ready_i=0 for 300 cycles, len=600, depth 256 -> no AR issued beyond FIFO space.
//      No data is lost or duplicated.
//  T5: one beat with rresp=2'b10 -> r_error_o=1 until the next start. All words are delivered.
//  T6: rst_i during DATA -> next cycle: all outputs 0, busy 0. A new transfer then succeeds.

Source files
------------

// File: rtl/iob_dma_read.sv
// iob_dma_read: AXI4 read master feeding an AXIS master through a FIFO whose
// storage is an external single-port-read RAM. The transfer is cut into INCR
// bursts limited by the programmed max length, the request remainder and the
// 4 KiB page. A burst is only requested once its words are guaranteed to fit.
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  S_IDLE  | waiting for a start pulse; not busy
//  S_CALC  | size the next burst, wait for enough FIFO free space
//  S_ADDR  | AR request presented, held until arready
//  S_DATA  | accepting R beats into the FIFO until rlast
//  S_DRAIN | all bursts fetched; wait for the stream to deliver the rest
module iob_dma_read #(
    parameter int AXI_ADDR_W = 32,
    parameter int AXI_LEN_W  = 8,
    parameter int AXI_DATA_W = 32,
    parameter int AXI_ID_W   = 1,
    parameter int DMA_RLEN_W = 24
) (
    input  logic                  clk_i,
    input  logic                  cke_i,
    input  logic                  rst_i,
    input  logic [AXI_ADDR_W-1:0] r_addr_i,
    input  logic [DMA_RLEN_W-1:0] r_length_i,
    input  logic                  r_start_transfer_i,
    input  logic [AXI_LEN_W:0]    r_max_len_i,
    output logic [DMA_RLEN_W-1:0] r_remaining_data_o,
    output logic                  r_busy_o,
    output logic                  r_error_o,
    output logic [AXI_DATA_W-1:0] axis_out_data_o,
    output logic                  axis_out_valid_o,
    input  logic                  axis_out_ready_i,
    output logic                  axis_out_last_o,
    output logic [AXI_ID_W-1:0]   m_axi_arid_o,
    output logic [AXI_ADDR_W-1:0] m_axi_araddr_o,
    output logic [AXI_LEN_W-1:0]  m_axi_arlen_o,
    output logic [2:0]            m_axi_arsize_o,
    output logic [1:0]            m_axi_arburst_o,
    output logic                  m_axi_arvalid_o,
    input  logic                  m_axi_arready_i,
    input  logic [AXI_ID_W-1:0]   m_axi_rid_i,
    input  logic [AXI_DATA_W-1:0] m_axi_rdata_i,
    input  logic [1:0]            m_axi_rresp_i,
    input  logic                  m_axi_rlast_i,
    input  logic                  m_axi_rvalid_i,
    output logic                  m_axi_rready_o,
    output logic                  ext_mem_clk_o,
    output logic                  ext_mem_w_en_o,
    output logic [AXI_LEN_W-1:0]  ext_mem_w_addr_o,
    output logic [AXI_DATA_W-1:0] ext_mem_w_data_o,
    output logic                  ext_mem_r_en_o,
    output logic [AXI_LEN_W-1:0]  ext_mem_r_addr_o,
    input  logic [AXI_DATA_W-1:0] ext_mem_r_data_i
);

    localparam int BYTES = AXI_DATA_W / 8;
    localparam int SZ    = $clog2(BYTES);
    localparam int LW    = AXI_LEN_W + 1;
    localparam int CW    = (DMA_RLEN_W > 14) ? DMA_RLEN_W : 14;
    localparam logic [LW-1:0] DEPTH = {1'b1, {AXI_LEN_W{1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_CALC,
        S_ADDR,
        S_DATA,
        S_DRAIN
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [AXI_ADDR_W-1:0] r_addr;
    logic [DMA_RLEN_W-1:0] r_req_left;
    logic [DMA_RLEN_W-1:0] r_remaining;
    logic                  r_error;
    logic [LW-1:0]         r_blen;
    logic [AXI_LEN_W-1:0]  r_arlen;
    logic [AXI_LEN_W-1:0]  r_wr_ptr;
    logic [AXI_LEN_W-1:0]  r_rd_ptr;
    logic [LW-1:0]         r_level;
    logic                  r_rd_pend;
    logic                  r_out_valid;
    logic [AXI_DATA_W-1:0] r_out_data;
    logic                  r_skid_valid;
    logic [AXI_DATA_W-1:0] r_skid_data;

    logic                  w_ar_hs;
    logic                  w_push;
    logic                  w_beat_last;
    logic                  w_axis_valid;
    logic                  w_hs;
    logic                  w_pop;
    logic [1:0]            w_stored;
    logic [LW-1:0]         w_free;
    logic [12:0]           w_bytes_to_4k;
    logic [CW-1:0]         w_to_4k;
    logic [CW-1:0]         w_max_len;
    logic [CW-1:0]         w_left;
    logic [CW-1:0]         w_min;
    logic [LW-1:0]         w_blen;
    logic                  w_unused_ok;

    assign w_unused_ok  = ^m_axi_rid_i;

    assign w_ar_hs      = (r_state == S_ADDR) && cke_i && m_axi_arready_i;
    assign w_push       = (r_state == S_DATA) && cke_i && m_axi_rvalid_i;
    assign w_beat_last  = w_push && m_axi_rlast_i;
    assign w_axis_valid = r_out_valid && cke_i;
    assign w_hs         = w_axis_valid && axis_out_ready_i;
    assign w_free       = DEPTH - r_level;

    // Words that will sit in out/skid after this edge. A RAM read is only
    // launched if its data is sure to find a slot even if the sink stalls.
    assign w_stored = 2'(r_out_valid) + 2'(r_skid_valid) + 2'(r_rd_pend) - 2'(w_hs);
    assign w_pop    = cke_i && (r_level != '0) && (w_stored < 2'd2);

    // Burst length: smallest of remaining words, programmed max and page room.
    always_comb begin
        w_bytes_to_4k = 13'h1000 - {1'b0, r_addr[11:0]};
        w_to_4k       = CW'(w_bytes_to_4k >> SZ);
        if (r_max_len_i == '0)
            w_max_len = CW'(1);
        else if (r_max_len_i > DEPTH)
            w_max_len = CW'(DEPTH);
        else
            w_max_len = CW'(r_max_len_i);
        w_left = CW'(r_req_left);
        w_min  = w_left;
        if (w_max_len < w_min)
            w_min = w_max_len;
        if (w_to_4k < w_min)
            w_min = w_to_4k;
        w_blen = LW'(w_min);
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i)
            r_state <= S_IDLE;
        else if (cke_i)
            r_state <= w_state_nxt;
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:
                if (r_start_transfer_i && (r_length_i != '0))
                    w_state_nxt = S_CALC;
            S_CALC:
                if (w_free >= w_blen)
                    w_state_nxt = S_ADDR;
            S_ADDR:
                if (w_ar_hs)
                    w_state_nxt = S_DATA;
            S_DATA:
                if (w_beat_last)
                    w_state_nxt = (r_req_left != DMA_RLEN_W'(r_blen)) ? S_CALC : S_DRAIN;
            S_DRAIN:
                if ((r_remaining == '0) || (w_hs && (r_remaining == DMA_RLEN_W'(1))))
                    w_state_nxt = S_IDLE;
            default:
                w_state_nxt = S_IDLE;
        endcase
    end

    // Transfer bookkeeping: address, words left to request, words left to deliver, error.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_addr      <= '0;
            r_req_left  <= '0;
            r_remaining <= '0;
            r_error     <= 1'b0;
            r_blen      <= '0;
            r_arlen     <= '0;
        end else if (cke_i) begin
            if (w_hs)
                r_remaining <= r_remaining - DMA_RLEN_W'(1);
            if ((r_state == S_IDLE) && r_start_transfer_i) begin
                r_addr      <= r_addr_i;
                r_req_left  <= r_length_i;
                r_remaining <= r_length_i;
                r_error     <= 1'b0;
            end
            if ((r_state == S_CALC) && (w_state_nxt == S_ADDR)) begin
                r_blen  <= w_blen;
                r_arlen <= AXI_LEN_W'(w_blen - LW'(1));
            end
            if (w_push && (m_axi_rresp_i != 2'b00))
                r_error <= 1'b1;
            if (w_beat_last) begin
                r_addr     <= r_addr + (AXI_ADDR_W'(r_blen) << SZ);
                r_req_left <= r_req_left - DMA_RLEN_W'(r_blen);
            end
        end
    end

    // FIFO pointers and fill level over the external RAM.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_level   <= '0;
            r_rd_pend <= 1'b0;
        end else if (cke_i) begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + AXI_LEN_W'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + AXI_LEN_W'(1);
            if (w_push && !w_pop)
                r_level <= r_level + LW'(1);
            else if (!w_push && w_pop)
                r_level <= r_level - LW'(1);
            r_rd_pend <= w_pop;
        end
    end

    // Output register with one skid slot; RAM data lands in whichever is next in order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
        end else if (cke_i) begin
            if (w_hs || !r_out_valid) begin
                if (r_skid_valid) begin
                    r_out_data   <= r_skid_data;
                    r_out_valid  <= 1'b1;
                    r_skid_valid <= r_rd_pend;
                    if (r_rd_pend)
                        r_skid_data <= ext_mem_r_data_i;
                end else begin
                    r_out_valid <= r_rd_pend;
                    if (r_rd_pend)
                        r_out_data <= ext_mem_r_data_i;
                end
            end else if (r_rd_pend) begin
                r_skid_data  <= ext_mem_r_data_i;
                r_skid_valid <= 1'b1;
            end
        end
    end

    assign r_remaining_data_o = r_remaining;
    assign r_busy_o           = (r_state != S_IDLE);
    assign r_error_o          = r_error;

    assign axis_out_data_o    = r_out_data;
    assign axis_out_valid_o   = w_axis_valid;
    assign axis_out_last_o    = w_axis_valid && (r_remaining == DMA_RLEN_W'(1));

    assign m_axi_arid_o       = '0;
    assign m_axi_araddr_o     = r_addr;
    assign m_axi_arlen_o      = r_arlen;
    assign m_axi_arsize_o     = 3'(SZ);
    assign m_axi_arburst_o    = 2'b01;
    assign m_axi_arvalid_o    = (r_state == S_ADDR) && cke_i;
    assign m_axi_rready_o     = (r_state == S_DATA) && cke_i;

    assign ext_mem_clk_o      = clk_i;
    assign ext_mem_w_en_o     = w_push;
    assign ext_mem_w_addr_o   = r_wr_ptr;
    assign ext_mem_w_data_o   = w_push ? m_axi_rdata_i : '0;
    assign ext_mem_r_en_o     = w_pop;
    assign ext_mem_r_addr_o   = r_rd_ptr;

endmodule

// File: tb/tb_iob_dma_read.sv
// Bench for iob_dma_read: AXI4 read slave, external RAM and AXIS sink are
// modelled here; expected bursts and stream contents come from a burst-split
// model and an address-hash memory image.
module tb_iob_dma_read;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        cke_i = 1'b1;
    logic        rst_i = 1'b1;
    logic [31:0] r_addr_i = '0;
    logic [23:0] r_length_i = '0;
    logic        r_start_transfer_i = 1'b0;
    logic [8:0]  r_max_len_i = '0;
    logic [23:0] r_remaining_data_o;
    logic        r_busy_o, r_error_o;
    logic [31:0] axis_out_data_o;
    logic        axis_out_valid_o, axis_out_last_o;
    logic        axis_out_ready_i = 1'b0;
    logic [0:0]  m_axi_arid_o;
    logic [31:0] m_axi_araddr_o;
    logic [7:0]  m_axi_arlen_o;
    logic [2:0]  m_axi_arsize_o;
    logic [1:0]  m_axi_arburst_o;
    logic        m_axi_arvalid_o, m_axi_rready_o;
    logic        m_axi_arready_i = 1'b0;
    logic [0:0]  m_axi_rid_i = '0;
    logic [31:0] m_axi_rdata_i = '0;
    logic [1:0]  m_axi_rresp_i = '0;
    logic        m_axi_rlast_i = 1'b0, m_axi_rvalid_i = 1'b0;
    logic        ext_mem_clk_o, ext_mem_w_en_o, ext_mem_r_en_o;
    logic [7:0]  ext_mem_w_addr_o, ext_mem_r_addr_o;
    logic [31:0] ext_mem_w_data_o;
    logic [31:0] ext_mem_r_data_i = '0;

    iob_dma_read dut (
        .clk_i(clk), .cke_i(cke_i), .rst_i(rst_i),
        .r_addr_i(r_addr_i), .r_length_i(r_length_i),
        .r_start_transfer_i(r_start_transfer_i), .r_max_len_i(r_max_len_i),
        .r_remaining_data_o(r_remaining_data_o), .r_busy_o(r_busy_o), .r_error_o(r_error_o),
        .axis_out_data_o(axis_out_data_o), .axis_out_valid_o(axis_out_valid_o),
        .axis_out_ready_i(axis_out_ready_i), .axis_out_last_o(axis_out_last_o),
        .m_axi_arid_o(m_axi_arid_o), .m_axi_araddr_o(m_axi_araddr_o),
        .m_axi_arlen_o(m_axi_arlen_o), .m_axi_arsize_o(m_axi_arsize_o),
        .m_axi_arburst_o(m_axi_arburst_o), .m_axi_arvalid_o(m_axi_arvalid_o),
        .m_axi_arready_i(m_axi_arready_i),
        .m_axi_rid_i(m_axi_rid_i), .m_axi_rdata_i(m_axi_rdata_i), .m_axi_rresp_i(m_axi_rresp_i),
        .m_axi_rlast_i(m_axi_rlast_i), .m_axi_rvalid_i(m_axi_rvalid_i),
        .m_axi_rready_o(m_axi_rready_o),
        .ext_mem_clk_o(ext_mem_clk_o), .ext_mem_w_en_o(ext_mem_w_en_o),
        .ext_mem_w_addr_o(ext_mem_w_addr_o), .ext_mem_w_data_o(ext_mem_w_data_o),
        .ext_mem_r_en_o(ext_mem_r_en_o), .ext_mem_r_addr_o(ext_mem_r_addr_o),
        .ext_mem_r_data_i(ext_mem_r_data_i)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct { logic [31:0] addr; int blen; } ar_t;
    typedef struct { logic [31:0] data; logic [1:0] resp; logic last; } beat_t;
    typedef struct { logic [31:0] addr; int len; int maxl; int rdy_pct; int stall; int err_beat; int exp_nar; } vec_t;

    ar_t         exp_ar[$];
    logic [31:0] exp_words[$];
    beat_t       beats[$];

    logic [31:0] ram [256];
    logic        pw_en = 1'b0, pr_en = 1'b0;
    logic [7:0]  pw_addr = '0, pr_addr = '0;
    logic [31:0] pw_data = '0;

    function automatic logic [31:0] memval(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    // Burst split from the rules: min(left, max (0->1, cap 256), words to next 4 KiB page).
    task automatic build_model(input logic [31:0] addr, input int len, input int maxl);
        logic [31:0] a;
        int left, m, to4k, b;
        exp_ar.delete();
        exp_words.delete();
        for (int i = 0; i < len; i++) exp_words.push_back(memval(addr + 32'(i) * 32'd4));
        a = addr;
        left = len;
        m = (maxl == 0) ? 1 : ((maxl > 256) ? 256 : maxl);
        while (left > 0) begin
            to4k = (4096 - int'(a[11:0])) / 4;
            b = left;
            if (m < b) b = m;
            if (to4k < b) b = to4k;
            exp_ar.push_back('{a, b});
            a = a + 32'(b * 4);
            left -= b;
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_busy"}, r_busy_o, 0);
        chk({tag, "_arvalid"}, m_axi_arvalid_o, 0);
        chk({tag, "_rready"}, m_axi_rready_o, 0);
        chk({tag, "_tvalid"}, axis_out_valid_o, 0);
        chk({tag, "_tlast"}, axis_out_last_o, 0);
        chk({tag, "_tdata"}, axis_out_data_o, 0);
        chk({tag, "_remaining"}, r_remaining_data_o, 0);
        chk({tag, "_error"}, r_error_o, 0);
        chk({tag, "_araddr"}, m_axi_araddr_o, 0);
        chk({tag, "_arlen"}, m_axi_arlen_o, 0);
        chk({tag, "_arsize_burst"}, {m_axi_arid_o, m_axi_arsize_o, m_axi_arburst_o}, {1'b0, 3'd2, 2'b01});
        chk({tag, "_mem_en"}, {ext_mem_w_en_o, ext_mem_r_en_o}, 0);
        chk({tag, "_mem_addr"}, {ext_mem_w_addr_o, ext_mem_r_addr_o, ext_mem_w_data_o}, 0);
    endtask

    task automatic run_xfer(input logic [31:0] addr, input int len, input int maxl, input int rdy_pct,
                            input int stall, input int err_beat, input int exp_nar, input bit abort,
                            output bit aborted);
        int nar, rcv, beat_idx, issued, cyc;
        bit done, r_taken, last_hs;
        beat_t b;
        build_model(addr, len, maxl);
        beats.delete();
        nar = 0; rcv = 0; beat_idx = 0; issued = 0;
        done = 0; r_taken = 0; last_hs = 0; aborted = 0;
        r_addr_i = addr;
        r_length_i = 24'(len);
        r_max_len_i = 9'(maxl);
        for (cyc = 0; cyc < 6000 && !done; cyc++) begin
            @(negedge clk);
            if (pw_en) ram[pw_addr] = pw_data;
            if (pr_en) ext_mem_r_data_i = ram[pr_addr];
            r_start_transfer_i = (cyc == 0);
            m_axi_arready_i = ($urandom_range(0, 1) == 1);
            if (r_taken) m_axi_rvalid_i = 1'b0;
            if (!m_axi_rvalid_i && beats.size() > 0 && $urandom_range(0, 3) != 0) begin
                m_axi_rvalid_i = 1'b1;
                m_axi_rdata_i = beats[0].data;
                m_axi_rresp_i = beats[0].resp;
                m_axi_rlast_i = beats[0].last;
            end
            axis_out_ready_i = (cyc >= stall) && ($urandom_range(1, 100) <= rdy_pct);
            #1;
            r_taken = 0;
            if (cyc == 1) begin
                chk("busy_after_start", r_busy_o, len != 0);
                chk("remaining_at_start", r_remaining_data_o, len);
                chk("error_cleared_on_start", r_error_o, 0);
            end
            if (last_hs) begin
                chk("busy_after_last", r_busy_o, 0);
                done = 1;
            end
            if (len == 0 && cyc == 4) done = 1;
            if (m_axi_arvalid_o && m_axi_arready_i) begin
                if (nar < exp_ar.size()) begin
                    chk("ar_addr", m_axi_araddr_o, exp_ar[nar].addr);
                    chk("ar_len", m_axi_arlen_o, exp_ar[nar].blen - 1);
                end
                chk("ar_id_size_burst", {m_axi_arid_o, m_axi_arsize_o, m_axi_arburst_o}, {1'b0, 3'd2, 2'b01});
                chk("ar_fits_fifo", (issued + int'(m_axi_arlen_o) + 1 - rcv) <= 258, 1);
                issued += int'(m_axi_arlen_o) + 1;
                for (int j = 0; j <= int'(m_axi_arlen_o); j++) begin
                    b.data = memval(m_axi_araddr_o + 32'(j * 4));
                    b.resp = (beat_idx == err_beat) ? 2'b10 : 2'b00;
                    b.last = (j == int'(m_axi_arlen_o));
                    beats.push_back(b);
                    beat_idx++;
                end
                nar++;
            end
            if (m_axi_rvalid_i && m_axi_rready_o) begin
                void'(beats.pop_front());
                r_taken = 1;
                if (abort) begin
                    aborted = 1;
                    done = 1;
                end
            end
            last_hs = 0;
            if (axis_out_valid_o && axis_out_ready_i) begin
                if (rcv < len) begin
                    chk("axis_data", axis_out_data_o, exp_words[rcv]);
                    chk("axis_last", axis_out_last_o, rcv == len - 1);
                end
                rcv++;
                if (rcv == len) last_hs = 1;
            end
            pw_en = ext_mem_w_en_o;
            pw_addr = ext_mem_w_addr_o;
            pw_data = ext_mem_w_data_o;
            pr_en = ext_mem_r_en_o;
            pr_addr = ext_mem_r_addr_o;
        end
        r_start_transfer_i = 1'b0;
        if (!aborted) begin
            chk("finished_in_budget", done, 1);
            chk("ar_count", nar, (exp_nar >= 0) ? exp_nar : exp_ar.size());
            chk("word_count", rcv, len);
            chk("error_flag", r_error_o, (err_beat >= 0) && (err_beat < len));
            chk("remaining_end", r_remaining_data_o, 0);
        end
    endtask

    vec_t vecs[10];
    bit   ab;

    initial begin
        vecs[0] = '{32'h0000_1000,   4,  16, 100,   0, -1, 1};
        vecs[1] = '{32'h0000_0000,  40,  16,  70,   0, -1, 3};
        vecs[2] = '{32'h0000_0FF8,   8,  16, 100,   0, -1, 2};
        vecs[3] = '{32'h0000_0000, 600, 256, 100, 300, -1, 3};
        vecs[4] = '{32'h0000_0200,  20,   8,  60,   0,  5, 3};
        vecs[5] = '{32'h0000_0040,   3,   0, 100,   0, -1, 3};
        vecs[6] = '{32'h0000_0000, 300, 300,  90,   0, -1, 2};
        vecs[7] = '{32'hFFFF_FFF0,   8,  16, 100,   0, -1, 2};
        vecs[8] = '{32'h0000_2000,   0,  16, 100,   0, -1, 0};
        vecs[9] = '{32'h0000_3F00,  64,  64,  40,   0, 63, 1};

        rst_i = 1'b1;
        repeat (3) @(negedge clk);
        rst_i = 1'b0;
        #1;
        check_idle("reset");

        for (int i = 0; i < 10; i++)
            run_xfer(vecs[i].addr, vecs[i].len, vecs[i].maxl, vecs[i].rdy_pct,
                     vecs[i].stall, vecs[i].err_beat, vecs[i].exp_nar, 1'b0, ab);

        for (int i = 0; i < 6; i++) begin
            logic [31:0] a;
            int len, eb;
            a = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 1) == 1) a[11:0] = 12'hF00 + 12'($urandom_range(0, 63) * 4);
            len = $urandom_range(1, 300);
            eb = ($urandom_range(0, 1) == 1) ? $urandom_range(0, len - 1) : -1;
            run_xfer(a, len, $urandom_range(0, 511), $urandom_range(30, 100), 0, eb, -1, 1'b0, ab);
        end

        run_xfer(32'h0, 40, 16, 100, 0, -1, -1, 1'b1, ab);
        chk("reset_test_reached_data", ab, 1);
        @(negedge clk);
        rst_i = 1'b1;
        m_axi_rvalid_i = 1'b0;
        beats.delete();
        pw_en = 1'b0;
        pr_en = 1'b0;
        @(negedge clk);
        rst_i = 1'b0;
        #1;
        check_idle("mid_reset");
        run_xfer(32'h100, 24, 8, 80, 0, -1, 3, 1'b0, ab);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
